// File: rtl/result_wr_sched_pkg.sv
// Shared types and default sizes for the result write scheduler.
//   state_e       : fill state of the result memory (EMPTY / FILL / FULL)
//   DEF_*         : default parameter values used by the top and its interface
package result_wr_pkg;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_MEM_WIDTH = 32;
  localparam int DEF_MEM_DEPTH = 8;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FILL  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

endpackage

// File: rtl/result_wr_sched_if.sv
// Producer handshake + result memory write bus of the write scheduler.
//   req_valid_i / req_data_i : producers -> scheduler (flattened data)
//   req_ready_o              : scheduler -> producers, one-hot grant
//   mem_we_o/addr_o/data_o   : scheduler -> result memory, registered write
// Modports: slave = scheduler side, master = producer/memory side.
interface result_wr_sched_if
  import result_wr_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int MEM_WIDTH = DEF_MEM_WIDTH,
  parameter int MEM_DEPTH = DEF_MEM_DEPTH
);
  localparam int AW = $clog2(MEM_DEPTH);

  logic [NUM_REQ-1:0]           req_valid_i;
  logic [NUM_REQ*MEM_WIDTH-1:0] req_data_i;
  logic [NUM_REQ-1:0]           req_ready_o;
  logic                         mem_we_o;
  logic [AW-1:0]                mem_addr_o;
  logic [MEM_WIDTH-1:0]         mem_data_o;

  modport slave (
    input  req_valid_i, req_data_i,
    output req_ready_o, mem_we_o, mem_addr_o, mem_data_o
  );

  modport master (
    output req_valid_i, req_data_i,
    input  req_ready_o, mem_we_o, mem_addr_o, mem_data_o
  );
endinterface

// File: rtl/result_wr_sched_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req    : request vector
//   ptr    : highest-priority index this cycle
//   en     : grant enable; gnt is all-zero when low
//   gnt    : one-hot grant to the first requester at or after ptr (modulo wrap)
//   winner : index of the granted requester (0 when nothing granted)
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PW-1:0]      winner
);

  always_comb begin
    int   idx;
    logic found;
    gnt    = '0;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    // Walk from ptr upward; ptr < NUM_REQ so one subtraction folds the wrap.
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (en && !found && req[idx[PW-1:0]]) begin
        found                = 1'b1;
        gnt[idx[PW-1:0]]     = 1'b1;
        winner               = idx[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/result_wr_sched.sv
// Result memory write scheduler.
// Round-robin picks one valid producer per cycle and issues one registered
// write at an auto-incrementing address. wrap_i=0 stops granting when the
// memory is full; wrap_i=1 keeps writing and overwrites the oldest entries.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   bus           : producer handshake and memory write port (slave side)
//   wrap_i        : 1 = circular overwrite, 0 = stop when full
//   clear_i       : synchronous clear of write pointer, count and state
//   count_o       : entries written since clear, saturating at MEM_DEPTH
//   full_o        : count_o == MEM_DEPTH
module result_wr_sched
  import result_wr_pkg::*;
#(
  parameter  int NUM_REQ   = DEF_NUM_REQ,
  parameter  int MEM_WIDTH = DEF_MEM_WIDTH,
  parameter  int MEM_DEPTH = DEF_MEM_DEPTH,
  localparam int AW        = $clog2(MEM_DEPTH),
  localparam int PW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  result_wr_sched_if.slave       bus,
  input  logic                   wrap_i,
  input  logic                   clear_i,
  output logic [AW:0]            count_o,
  output logic                   full_o
);

  localparam logic [AW:0]   DEPTH_C = (AW+1)'(MEM_DEPTH);
  localparam logic [PW-1:0] LAST_C  = PW'(NUM_REQ - 1);

  state_e                state_q, state_d;
  logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW:0]           count_q, count_d;
  logic                  we_q, we_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [MEM_WIDTH-1:0]  data_q, data_d;

  logic                  accept;
  logic [NUM_REQ-1:0]    gnt;
  logic [PW-1:0]         winner;
  logic [MEM_WIDTH-1:0]  win_data;

  // rst_ni gates the grant so ready stays low while reset is held.
  assign accept = rst_ni && (|bus.req_valid_i) && !clear_i &&
                  !(state_q == ST_FULL && !wrap_i);

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req    (bus.req_valid_i),
    .ptr    (rr_ptr_q),
    .en     (accept),
    .gnt    (gnt),
    .winner (winner)
  );

  assign bus.req_ready_o = gnt;

  // One-hot AND-OR mux of the granted producer's data.
  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt[i]) win_data = win_data | bus.req_data_i[i*MEM_WIDTH +: MEM_WIDTH];
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    we_d     = accept;
    addr_d   = addr_q;
    data_d   = data_q;
    if (clear_i) begin
      // rr_ptr deliberately survives a clear.
      state_d  = ST_EMPTY;
      wr_ptr_d = '0;
      count_d  = '0;
    end else if (accept) begin
      rr_ptr_d = (winner == LAST_C) ? '0 : winner + 1'b1;
      wr_ptr_d = wr_ptr_q + 1'b1;
      count_d  = (count_q == DEPTH_C) ? DEPTH_C : count_q + 1'b1;
      state_d  = (count_d == DEPTH_C) ? ST_FULL : ST_FILL;
      addr_d   = wr_ptr_q;
      data_d   = win_data;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_EMPTY;
      rr_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

  assign bus.mem_we_o   = we_q;
  assign bus.mem_addr_o = addr_q;
  assign bus.mem_data_o = data_q;
  assign count_o        = count_q;
  assign full_o         = (state_q == ST_FULL);

endmodule

// File: tb/tb_result_wr_sched.sv
// Self-checking bench for result_wr_sched (NUM_REQ=4, MEM_WIDTH=32, MEM_DEPTH=8).
// A reference model predicts each grant; predicted writes go into a scoreboard
// queue and are popped when the registered write appears one cycle later.
module tb_result_wr_sched;

  localparam int NR = 4;
  localparam int MW = 32;
  localparam int MD = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wrap = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] count;
  logic       full;

  result_wr_sched_if #(.NUM_REQ(NR), .MEM_WIDTH(MW), .MEM_DEPTH(MD)) bus ();

  result_wr_sched #(.NUM_REQ(NR), .MEM_WIDTH(MW), .MEM_DEPTH(MD)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .bus     (bus),
    .wrap_i  (wrap),
    .clear_i (clear),
    .count_o (count),
    .full_o  (full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [3:0] v;
    logic       clr;
    logic       wr;
    logic [3:0] rdy;
    logic [3:0] cnt;
    logic       full;
  } vec_t;

  wr_t  sb[$];
  vec_t tbl[12];
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_wr = 0;
  int   m_rr = 0, m_wr = 0, m_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic default_data();
    for (int i = 0; i < NR; i++) bus.req_data_i[i*MW +: MW] = 32'hA0 + i;
  endtask

  // Called at posedge+1: drive, predict and check ready, clock, check write/status.
  task automatic step(input logic [3:0] v, input logic clr, input logic wr,
                      output logic [3:0] rdy);
    logic [3:0] mg;
    int         win;
    bit         acc;
    wr_t        e;
    bus.req_valid_i = v;
    clear = clr;
    wrap  = wr;
    #1;
    acc = (v != 0) && !clr && !(m_cnt == MD && !wr);
    mg  = '0;
    win = -1;
    if (acc) begin
      win = m_rr;
      while (!v[win]) win = (win + 1) % NR;
      mg[win] = 1'b1;
    end
    rdy = bus.req_ready_o;
    chk("ready", 64'(rdy), 64'(mg));
    if (acc) begin
      e.addr = 3'(m_wr);
      e.data = bus.req_data_i[win*MW +: MW];
      sb.push_back(e);
      m_rr  = (win + 1) % NR;
      m_wr  = (m_wr + 1) % MD;
      if (m_cnt < MD) m_cnt++;
    end
    if (clr) begin
      m_wr  = 0;
      m_cnt = 0;
    end
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("mem_we", 64'(bus.mem_we_o), 64'd1);
      chk("mem_addr", 64'(bus.mem_addr_o), 64'(e.addr));
      chk("mem_data", 64'(bus.mem_data_o), 64'(e.data));
      n_wr++;
    end else begin
      chk("mem_we_idle", 64'(bus.mem_we_o), 64'd0);
    end
    chk("count", 64'(count), 64'(m_cnt));
    chk("full", 64'(full), 64'(m_cnt == MD));
  endtask

  // One producer offers n words, advancing to the next word only when granted.
  task automatic stream(input int prod, input int n, input logic wr, input int exp_wr);
    logic [3:0] rdy;
    int         k;
    step(4'b0000, 1'b1, wr, rdy);
    n_wr = 0;
    k = 0;
    for (int c = 0; c < n + 4; c++) begin
      bus.req_data_i[prod*MW +: MW] = 32'hD00 + k;
      step((k < n) ? 4'(1 << prod) : 4'b0000, 1'b0, wr, rdy);
      if (rdy[prod]) k++;
    end
    chk("stream_writes", 64'(n_wr), 64'(exp_wr));
    default_data();
  endtask

  initial begin
    logic [3:0] rdy;
    bus.req_valid_i = '0;
    default_data();

    // Hand-derived round-robin / full / clear vectors, starting from reset.
    tbl[0]  = '{4'b1111, 1'b0, 1'b1, 4'b0001, 4'd1, 1'b0};
    tbl[1]  = '{4'b1111, 1'b0, 1'b1, 4'b0010, 4'd2, 1'b0};
    tbl[2]  = '{4'b1111, 1'b0, 1'b1, 4'b0100, 4'd3, 1'b0};
    tbl[3]  = '{4'b1111, 1'b0, 1'b1, 4'b1000, 4'd4, 1'b0};
    tbl[4]  = '{4'b1010, 1'b0, 1'b1, 4'b0010, 4'd5, 1'b0};
    tbl[5]  = '{4'b1010, 1'b0, 1'b1, 4'b1000, 4'd6, 1'b0};
    tbl[6]  = '{4'b0001, 1'b0, 1'b1, 4'b0001, 4'd7, 1'b0};
    tbl[7]  = '{4'b0001, 1'b0, 1'b1, 4'b0001, 4'd8, 1'b1};
    tbl[8]  = '{4'b1111, 1'b0, 1'b0, 4'b0000, 4'd8, 1'b1};
    tbl[9]  = '{4'b1100, 1'b1, 1'b1, 4'b0000, 4'd0, 1'b0};
    tbl[10] = '{4'b0101, 1'b0, 1'b1, 4'b0100, 4'd1, 1'b0};
    tbl[11] = '{4'b1111, 1'b0, 1'b1, 4'b1000, 4'd2, 1'b0};

    // Reset and idle.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", 64'(bus.mem_we_o), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step(4'b0000, 1'b0, 1'b0, rdy);
      chk("idle_addr", 64'(bus.mem_addr_o), 64'd0);
      chk("idle_data", 64'(bus.mem_data_o), 64'd0);
    end

    // Table vectors: fairness, stop-at-full, clear collision keeping rr_ptr.
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].v, tbl[i].clr, tbl[i].wr, rdy);
      chk($sformatf("tbl%0d_ready", i), 64'(rdy), 64'(tbl[i].rdy));
      chk($sformatf("tbl%0d_count", i), 64'(count), 64'(tbl[i].cnt));
      chk($sformatf("tbl%0d_full", i), 64'(full), 64'(tbl[i].full));
    end

    // Stop when full, then circular overwrite.
    stream(2, 10, 1'b0, 8);
    chk("stop_full", 64'(full), 64'd1);
    stream(1, 10, 1'b1, 10);
    chk("wrap_count", 64'(count), 64'd8);
    chk("wrap_last_addr", 64'(bus.mem_addr_o), 64'd1);

    // Reset mid-burst: pending write is dropped at once.
    step(4'b0010, 1'b0, 1'b1, rdy);
    step(4'b1111, 1'b0, 1'b1, rdy);
    chk("burst_we", 64'(bus.mem_we_o), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_we", 64'(bus.mem_we_o), 64'd0);
    chk("rst_mid_count", 64'(count), 64'd0);
    chk("rst_mid_ready", 64'(bus.req_ready_o), 64'd0);
    sb.delete();
    m_rr = 0; m_wr = 0; m_cnt = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(4'b1111, 1'b0, 1'b1, rdy);
    chk("post_rst_grant", 64'(rdy), 64'd1);
    chk("post_rst_addr", 64'(bus.mem_addr_o), 64'd0);
    chk("post_rst_data", 64'(bus.mem_data_o), 64'hA0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
